hazard_stall_ctrl: RTL
======================

// Module: hazard_stall_ctrl
// PURPOSE
//  Pipeline sequencing controller for the 5-stage core. Detects load-use hazards, flushes on taken
//  branches and freezes the pipe during multi-cycle data-memory accesses via a wait-state FSM.
//  Inputs come from the ID/EX/MEM pipeline registers; outputs drive PC/IF-ID enables, flushes, and
//  the ID/EX bubble mux that zeroes the decoded control word.
// PARAMETERS
//  REG_AW    5   register address width
//  MAX_WAIT  15  max MEM_WAIT cycles before timeout error (1..2^WAIT_W-1)
//  WAIT_W    4   wait counter width
//  CNT_W     16  stall cycle counter width
// PORTS
//  clk             in   1       clock, rising edge
//  rst_n           in   1       asynchronous active-low reset
//  id_rs1          in   REG_AW  rs1 of instruction in ID
//  id_rs2          in   REG_AW  rs2 of instruction in ID
//  id_uses_rs2     in   1       ID instr reads rs2 (R-type, store, branch)
//  ex_rd           in   REG_AW  rd of instruction in EX
//  ex_memread      in   1       EX instr is a load
//  ex_branch_taken in   1       branch resolved taken in EX
//  mem_access      in   1       MEM instr has MemRead or MemWrite
//  dmem_ready      in   1       data memory completes access this cycle
//  pc_write        out  1       PC load enable
//  ifid_write      out  1       IF/ID register enable
//  idex_bubble     out  1       force zero control word into ID/EX
//  ifid_flush      out  1       clear IF/ID to NOP
//  idex_flush      out  1       clear ID/EX to NOP
//  pipe_freeze     out  1       hold ID/EX, EX/MEM, MEM/WB registers
//  dmem_req        out  1       request to data memory
//  mem_err         out  1       sticky memory timeout flag
//  stall_cycles    out  CNT_W   count of cycles with pc_write==0
// BEHAVIOUR
//  States: RUN, MEM_WAIT, ERR (registered). Wait counter wcnt (WAIT_W bits) registered.
//  Reset (rst_n=0, async): state=RUN, wcnt=0, mem_err=0, stall_cycles=0; while rst_n=0 outputs forced:
//   pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=1, idex_flush=1, pipe_freeze=0, dmem_req=0.
//  All other outputs combinational from state + inputs (0 latency); state updates on rising clk.
//  load_use = ex_memread & ex_rd!=0 & (ex_rd==id_rs1 | (id_uses_rs2 & ex_rd==id_rs2)).
//  frz = (RUN & mem_access & ~dmem_ready) | (MEM_WAIT & ~dmem_ready) | ERR.
//  Priority, highest first:
//   1 frz: pipe_freeze=1, pc_write=0, ifid_write=0; bubble/flushes=0 (branch held, re-evaluated later).
//   2 ex_branch_taken: ifid_flush=1, idex_flush=1, pc_write=1, ifid_write=1; load_use ignored.
//   3 load_use: pc_write=0, ifid_write=0, idex_bubble=1 for exactly that cycle.
//   4 else: pc_write=1, ifid_write=1, all others 0.
//  dmem_req = mem_access & state!=ERR.
//  Transitions:
//   RUN: mem_access & ~dmem_ready -> MEM_WAIT, wcnt<=1. Zero-wait (ready same cycle) stays RUN.
//   MEM_WAIT: dmem_ready -> RUN, wcnt<=0, pipe advances in that same cycle (frz=0).
//     ~dmem_ready & wcnt==MAX_WAIT -> ERR, mem_err<=1; else wcnt<=wcnt+1.
//   ERR: terminal until rst_n; freeze held, dmem_req=0, mem_err=1.
//  stall_cycles: +1 each clk with pc_write==0 out of reset; saturates at 2^CNT_W-1, no wrap.
//  Reset asserted mid-MEM_WAIT: immediately RUN, freeze drops, outstanding request abandoned.
//  rd==x0 never causes a load-use stall.
// TESTING
//  T1 ex_memread=1, ex_rd=5, id_rs1=5 -> one cycle pc_write=0, ifid_write=0, idex_bubble=1; next cycle normal.
//  T2 load-use + ex_branch_taken same cycle -> flushes=1, pc_write=1, idex_bubble=0.
//  T3 ex_rd=0, id_rs1=0, ex_memread=1 -> no stall; id_uses_rs2=0, id_rs2=ex_rd=7 -> no stall.
//  T4 mem_access=1, dmem_ready low 3 cycles then high -> pipe_freeze=1 for 3 cycles, RUN on 4th, stall_cycles=3.
//  T5 dmem_ready never high, MAX_WAIT=15 -> ERR after 16 frozen cycles, mem_err=1, dmem_req=0, sticky.
//  T6 rst_n low during MEM_WAIT -> async return to reset values; after release RUN, mem_err=0, stall_cycles=0.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: load-use stalls, branch flushes and a
// wait-state FSM that freezes the pipe during multi-cycle data-memory accesses.
//
// state    | meaning
// RUN      | normal issue, memory access completes same cycle or enters MEM_WAIT
// MEM_WAIT | data memory busy, pipe frozen, wcnt counts wait cycles
// ERR      | memory timeout, pipe frozen until reset, mem_err set
module hazard_stall_ctrl #(
  parameter int REG_AW   = 5,
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 4,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_memread,
  input  logic              ex_branch_taken,
  input  logic              mem_access,
  input  logic              dmem_ready,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              idex_bubble,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              pipe_freeze,
  output logic              dmem_req,
  output logic              mem_err,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] ERR      = 2'd2;

  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  logic [1:0]        state;
  logic [WAIT_W-1:0] wcnt;
  logic              load_use;
  logic              frz;

  assign load_use = ex_memread && (ex_rd != '0) &&
                    ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

  assign frz = ((state == RUN) && mem_access && !dmem_ready) ||
               ((state == MEM_WAIT) && !dmem_ready) ||
               (state == ERR);

  // Reset overrides the output decode so the pipe sees NOPs while rst_n is low.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    pipe_freeze = 1'b0;
    dmem_req    = mem_access && (state != ERR);
    if (!rst_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      dmem_req    = 1'b0;
    end else if (frz) begin
      pipe_freeze = 1'b1;
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
    end else if (ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      wcnt    <= '0;
      mem_err <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mem_access && !dmem_ready) begin
            state <= MEM_WAIT;
            wcnt  <= WAIT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (dmem_ready) begin
            state <= RUN;
            wcnt  <= '0;
          end else if (wcnt == WAIT_LIMIT) begin
            state   <= ERR;
            mem_err <= 1'b1;
          end else begin
            wcnt <= wcnt + WAIT_W'(1);
          end
        end
        ERR: begin
          state   <= ERR;
          mem_err <= 1'b1;
        end
        default: begin
          state <= RUN;
          wcnt  <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (!pc_write && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule
